// File: rtl/fpseq_if.sv
// Signal bundle between the AWP control / F-PM unit and the FPU phase sequencer.
// The master drives instruction class and status flags; the sequencer drives phases and strobes.
interface fpseq_if;
  logic start;
  logic ad_sd, af_sf, mw_mf, dw_df, ff;
  logic g, fic, nz, ws, fault;
  logic f2, f4, f5, f6, f7, f8, f9, f10, f13;
  logic strob_fp, strob2_fp;
  logic busy, done, abort;

  modport master (
    output start, ad_sd, af_sf, mw_mf, dw_df, ff, g, fic, nz, ws, fault,
    input  f2, f4, f5, f6, f7, f8, f9, f10, f13, strob_fp, strob2_fp, busy, done, abort
  );

  modport slave (
    input  start, ad_sd, af_sf, mw_mf, dw_df, ff, g, fic, nz, ws, fault,
    output f2, f4, f5, f6, f7, f8, f9, f10, f13, strob_fp, strob2_fp, busy, done, abort
  );
endinterface

// File: rtl/fpseq.sv
// FPU phase sequencer for the AWP path: walks the F2..F13 phase graph and
// produces registered one-hot phase lines, per-phase strobes and busy/done/abort.
module fpseq #(
  parameter int PHASE_TICKS = 4,
  parameter int MAX_LOOP    = 63
) (
  input  logic   __clk,
  input  logic   _0_f,
  fpseq_if.slave bus
);

  localparam int TW = $clog2(PHASE_TICKS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(PHASE_TICKS - 1);
  localparam logic [TW-1:0] TICK_STROB = TW'(PHASE_TICKS - 2);
  localparam logic [5:0]    LOOP_MAX   = 6'(MAX_LOOP);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F2   = 4'd1;
  localparam logic [3:0] S_F4   = 4'd2;
  localparam logic [3:0] S_F5   = 4'd3;
  localparam logic [3:0] S_F6   = 4'd4;
  localparam logic [3:0] S_F7   = 4'd5;
  localparam logic [3:0] S_F8   = 4'd6;
  localparam logic [3:0] S_F9   = 4'd7;
  localparam logic [3:0] S_F10  = 4'd8;
  localparam logic [3:0] S_F13  = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    loop_q, loop_d;
  logic [8:0]    phase_q, phase_d;
  logic          strob_q, strob_d;
  logic          strob2_q, strob2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          last_tick;
  logic          stay;
  logic          unused_class;

  // mw/dw are implied by the absence of ad/af, so only the latter steer the graph
  assign unused_class = bus.mw_mf ^ bus.dw_df;

  assign last_tick = (tick_q == TICK_LAST);
  assign stay      = ((state_q == S_F8) && !bus.fic) || ((state_q == S_F9) && bus.nz);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (state_q == S_IDLE) begin
      tick_d = '0;
      if (bus.start) state_d = S_F2;
    end else if (!last_tick) begin
      tick_d = tick_q + 1'b1;
    end else begin
      tick_d = '0;
      if (bus.fault) begin
        state_d = S_IDLE;
        abort_d = 1'b1;
      end else begin
        case (state_q)
          S_F2:  state_d = bus.ad_sd ? S_F6 : S_F4;
          S_F4:  state_d = bus.af_sf ? S_F5 : S_F8;
          S_F5:  state_d = bus.g ? S_F10 : S_F8;
          S_F6:  state_d = S_F7;
          S_F7:  state_d = bus.ff ? S_F9 : S_F13;
          S_F8, S_F9: begin
            if (!stay) begin
              state_d = (state_q == S_F8) ? S_F6 : S_F10;
            end else if (loop_q == LOOP_MAX) begin
              state_d = S_IDLE;
              abort_d = 1'b1;
            end else begin
              loop_d = loop_q + 6'd1;
            end
          end
          S_F10: state_d = bus.ws ? S_F7 : S_F13;
          S_F13: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
      // A fresh F8/F9 run starts counting from zero
      if ((state_d == S_F8 || state_d == S_F9) && state_d != state_q) loop_d = '0;
    end
  end

  always_comb begin
    phase_d = '0;
    case (state_d)
      S_F2:    phase_d[0] = 1'b1;
      S_F4:    phase_d[1] = 1'b1;
      S_F5:    phase_d[2] = 1'b1;
      S_F6:    phase_d[3] = 1'b1;
      S_F7:    phase_d[4] = 1'b1;
      S_F8:    phase_d[5] = 1'b1;
      S_F9:    phase_d[6] = 1'b1;
      S_F10:   phase_d[7] = 1'b1;
      S_F13:   phase_d[8] = 1'b1;
      default: phase_d    = '0;
    endcase
    busy_d   = (state_d != S_IDLE);
    strob_d  = busy_d && (tick_d == TICK_STROB);
    strob2_d = busy_d && (tick_d == TICK_LAST);
  end

  always_ff @(posedge __clk) begin
    if (_0_f) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      loop_q   <= '0;
      phase_q  <= '0;
      strob_q  <= 1'b0;
      strob2_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      loop_q   <= loop_d;
      phase_q  <= phase_d;
      strob_q  <= strob_d;
      strob2_q <= strob2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.f2        = phase_q[0];
  assign bus.f4        = phase_q[1];
  assign bus.f5        = phase_q[2];
  assign bus.f6        = phase_q[3];
  assign bus.f7        = phase_q[4];
  assign bus.f8        = phase_q[5];
  assign bus.f9        = phase_q[6];
  assign bus.f10       = phase_q[7];
  assign bus.f13       = phase_q[8];
  assign bus.strob_fp  = strob_q;
  assign bus.strob2_fp = strob2_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_fpseq.sv
// Bench for fpseq: plans each run as a list of phases from the phase-graph rules,
// then drives it and compares every cycle's outputs against the planned waveform.
module tb_fpseq;
  localparam int PT = 4;
  localparam int ML = 3;

  localparam int P_F2 = 0, P_F4 = 1, P_F5 = 2, P_F6 = 3, P_F7 = 4;
  localparam int P_F8 = 5, P_F9 = 6, P_F10 = 7, P_F13 = 8, P_END = 9;
  localparam int END_DONE = 1, END_ABORT = 2;

  typedef struct {
    int ph;
    bit g, fic, nz, ws;
    int ftick;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  fpseq_if bus();

  fpseq #(.PHASE_TICKS(PT), .MAX_LOOP(ML)) dut (
    .__clk (clk),
    ._0_f  (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  step_t plan[$];
  int    plan_end;
  bit    q_g[$], q_fic[$], q_nz[$], q_ws[$];
  bit    directed;
  int    fault_idx, fault_tick;
  bit    cls_ad, cls_af, cls_mw, cls_dw, cls_ff;
  bit    start_all;

  logic [13:0] e_vec;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  string lit_name;
  int    lit_act, lit_exp;
  int    lit_req = 0;
  int    lit_served = 0;

  int mon_cyc, mon_end_cyc, mon_done, mon_abort;
  int mon_cnt[9];
  bit prev_busy;

  // Successor phase by the graph rules; F8/F9 self-loops return the same phase
  function automatic int next_of(int p, step_t s);
    case (p)
      P_F2:    return cls_ad ? P_F6 : P_F4;
      P_F4:    return cls_af ? P_F5 : P_F8;
      P_F5:    return s.g ? P_F10 : P_F8;
      P_F8:    return s.fic ? P_F6 : P_F8;
      P_F6:    return P_F7;
      P_F7:    return cls_ff ? P_F9 : P_F13;
      P_F9:    return s.nz ? P_F9 : P_F10;
      P_F10:   return s.ws ? P_F7 : P_F13;
      default: return P_END;
    endcase
  endfunction

  task automatic build_plan();
    int p   = P_F2;
    int run = 1;
    int nxt;
    step_t s;
    plan.delete();
    forever begin
      s.ph = p;
      if (directed) begin
        s.g = 1'b0; s.fic = 1'b1; s.nz = 1'b0; s.ws = 1'b0;
        if (p == P_F5  && q_g.size()   > 0) s.g   = q_g.pop_front();
        if (p == P_F8  && q_fic.size() > 0) s.fic = q_fic.pop_front();
        if (p == P_F9  && q_nz.size()  > 0) s.nz  = q_nz.pop_front();
        if (p == P_F10 && q_ws.size()  > 0) s.ws  = q_ws.pop_front();
        s.ftick = (plan.size() == fault_idx) ? fault_tick : -1;
      end else begin
        s.g   = ($urandom_range(0, 3) == 0);
        s.fic = ($urandom_range(0, 2) != 0);
        s.nz  = ($urandom_range(0, 2) == 0);
        s.ws  = ($urandom_range(0, 3) == 0);
        s.ftick = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, PT - 1)) : -1;
        if (plan.size() > 40) begin
          s.ws = 1'b0; s.nz = 1'b0; s.fic = 1'b1;
        end
      end
      if (s.ftick == PT - 1) begin
        plan.push_back(s); plan_end = END_ABORT; break;
      end
      nxt = next_of(p, s);
      // At most ML+1 consecutive phases of the same F8/F9 run
      if (nxt == p) begin
        if (run - 1 == ML) begin
          plan.push_back(s); plan_end = END_ABORT; break;
        end
        run++;
      end else begin
        run = 1;
      end
      plan.push_back(s);
      if (nxt == P_END) begin
        plan_end = END_DONE; break;
      end
      p = nxt;
    end
  endtask

  task automatic set_exp(input logic [8:0] ph, input bit s1, input bit s2,
                         input bit bz, input bit dn, input bit ab);
    e_vec  = {ph, s1, s2, bz, dn, ab};
    chk_en = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.fault = 1'($urandom_range(0, 1));
      set_exp(9'd0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic run_plan(input int rst_i, input int rst_t);
    logic [8:0] oh;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ad_sd = cls_ad; bus.af_sf = cls_af; bus.mw_mf = cls_mw; bus.dw_df = cls_dw;
    bus.ff    = cls_ff;
    bus.fault = 1'($urandom_range(0, 1));
    set_exp(9'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < plan.size(); i++) begin
      for (int t = 0; t < PT; t++) begin
        @(posedge clk); #1;
        oh = 9'b1 << plan[i].ph;
        bus.start = start_all ? 1'b1 : ($urandom_range(0, 7) == 0);
        if (t == PT - 1) begin
          bus.g = plan[i].g; bus.fic = plan[i].fic; bus.nz = plan[i].nz; bus.ws = plan[i].ws;
        end else begin
          bus.g  = 1'($urandom_range(0, 1)); bus.fic = 1'($urandom_range(0, 1));
          bus.nz = 1'($urandom_range(0, 1)); bus.ws  = 1'($urandom_range(0, 1));
        end
        bus.fault = (t == plan[i].ftick);
        set_exp(oh, t == PT - 2, t == PT - 1, 1, 0, 0);
        if (i == rst_i && t == rst_t) begin
          rst = 1'b1; bus.start = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0; bus.start = 1'b0; bus.fault = 1'b0;
          set_exp(9'd0, 0, 0, 0, 0, 0);
          idle_gap(3);
          return;
        end
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.fault = 1'($urandom_range(0, 1));
    set_exp(9'd0, 0, 0, 0, plan_end == END_DONE, plan_end == END_ABORT);
    idle_gap($urandom_range(1, 3));
  endtask

  task automatic lit_check(input string name, input int act, input int exp);
    lit_name = name; lit_act = act; lit_exp = exp;
    lit_req++;
    @(negedge clk); #1;
  endtask

  task automatic set_class(input int c, input bit ffv);
    cls_ad = (c == 0); cls_af = (c == 1); cls_mw = (c == 2); cls_dw = (c == 3);
    cls_ff = ffv;
  endtask

  task automatic clear_directed();
    q_g.delete(); q_fic.delete(); q_nz.delete(); q_ws.delete();
    fault_idx = -1; fault_tick = -1; directed = 1'b1; start_all = 1'b0;
  endtask

  // Single compare point: per-cycle waveform, plus queued literal checks and run statistics
  always @(negedge clk) begin : compare
    logic [13:0] act;
    act = {bus.f13, bus.f10, bus.f9, bus.f8, bus.f7, bus.f6, bus.f5, bus.f4, bus.f2,
           bus.strob_fp, bus.strob2_fp, bus.busy, bus.done, bus.abort};
    if (chk_en) begin
      checks++;
      if (act !== e_vec) begin
        errors++;
        $display("[TB] FAIL cycle_outputs t=%0t act=%b exp=%b", $time, act, e_vec);
      end
      if (bus.busy && !prev_busy) begin
        mon_cyc = 0; mon_done = 0; mon_abort = 0;
        for (int k = 0; k < 9; k++) mon_cnt[k] = 0;
      end else if (prev_busy) begin
        mon_cyc++;
      end
      if (bus.strob2_fp)
        for (int k = 0; k < 9; k++) if (act[k + 5]) mon_cnt[k]++;
      if (bus.done)  begin mon_done  = 1; mon_end_cyc = mon_cyc; end
      if (bus.abort) begin mon_abort = 1; mon_end_cyc = mon_cyc; end
      prev_busy = bus.busy;
    end
    if (lit_req != lit_served) begin
      lit_served = lit_req;
      checks++;
      if (lit_act != lit_exp) begin
        errors++;
        $display("[TB] FAIL %s act=%0d exp=%0d", lit_name, lit_act, lit_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.ad_sd = 1'b0; bus.af_sf = 1'b0; bus.mw_mf = 1'b0; bus.dw_df = 1'b0;
    bus.ff = 1'b0; bus.g = 1'b0; bus.fic = 1'b0; bus.nz = 1'b0; bus.ws = 1'b0; bus.fault = 1'b0;
    prev_busy = 1'b0;
    clear_directed();
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    set_exp(9'd0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    set_exp(9'd0, 0, 0, 0, 0, 0);
    idle_gap(2);

    $display("[TB] AF full path");
    clear_directed(); set_class(1, 1'b1); q_fic.push_back(1'b1);
    build_plan();
    lit_check("af_plan_len", plan.size(), 9);
    run_plan(-1, -1);
    lit_check("af_done_cycles", mon_end_cyc, 36);
    lit_check("af_done_seen", mon_done, 1);

    $display("[TB] AF with g=1 skip");
    clear_directed(); set_class(1, 1'b0); q_g.push_back(1'b1);
    build_plan();
    run_plan(-1, -1);
    lit_check("g_skip_f8", mon_cnt[P_F8], 0);
    lit_check("g_skip_f6", mon_cnt[P_F6], 0);
    lit_check("g_skip_f7", mon_cnt[P_F7], 0);
    lit_check("g_skip_f10", mon_cnt[P_F10], 1);

    $display("[TB] MF loop overrun");
    clear_directed(); set_class(2, 1'b0);
    repeat (8) q_fic.push_back(1'b0);
    build_plan();
    run_plan(-1, -1);
    lit_check("loop_f8_phases", mon_cnt[P_F8], 4);
    lit_check("loop_abort", mon_abort, 1);
    lit_check("loop_no_done", mon_done, 0);

    $display("[TB] AF normalize and correction");
    clear_directed(); set_class(1, 1'b1); q_fic.push_back(1'b1);
    q_nz.push_back(1'b1); q_nz.push_back(1'b1);
    q_ws.push_back(1'b1); q_ws.push_back(1'b0);
    build_plan();
    lit_check("nz_plan_len", plan.size(), 14);
    run_plan(-1, -1);
    lit_check("nz_f9_phases", mon_cnt[P_F9], 4);
    lit_check("nz_f7_phases", mon_cnt[P_F7], 2);
    lit_check("nz_f10_phases", mon_cnt[P_F10], 2);

    $display("[TB] fault in F4, then start held during a later run");
    clear_directed(); set_class(2, 1'b0); fault_idx = 1; fault_tick = PT - 1;
    build_plan();
    run_plan(-1, -1);
    lit_check("fault_abort", mon_abort, 1);
    lit_check("fault_cycles", mon_end_cyc, 8);
    clear_directed(); set_class(0, 1'b0); start_all = 1'b1;
    build_plan();
    run_plan(-1, -1);
    lit_check("start_ignored_cycles", mon_end_cyc, 16);

    $display("[TB] reset during F7");
    clear_directed(); set_class(1, 1'b1);
    build_plan();
    run_plan(5, 1);
    lit_check("reset_no_done", mon_done, 0);
    lit_check("reset_no_abort", mon_abort, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 150; r++) begin
      clear_directed();
      directed  = 1'b0;
      start_all = ($urandom_range(0, 3) == 0);
      set_class($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      build_plan();
      if ($urandom_range(0, 19) == 0)
        run_plan($urandom_range(0, plan.size() - 1), $urandom_range(0, PT - 1));
      else
        run_plan(-1, -1);
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
